// File: rtl/sequence_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, with repeats and idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every frame.
module sequence_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [LEN_W-1:0] length_in,
    input  logic [CNT_W-1:0] repeat_in,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    output logic             sequence_out,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_PAR   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pat;
    logic [WIDTH-1:0]   w_pat_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [CNT_W-1:0]   r_rep;
    logic [CNT_W-1:0]   w_rep_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_nxt;

    logic               r_seq;
    logic               w_seq_nxt;
    logic               r_fs;
    logic               w_fs_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_ready;
    logic               w_ready_nxt;

    logic               w_frame_end;
    logic [LEN_W-1:0]   w_len_norm;
    logic [IDX_W-1:0]   w_first_idx;
    logic [IDX_W-1:0]   w_reload_idx;

    // Length 0 or anything above WIDTH means a full-width frame
    assign w_len_norm   = ((length_in == '0) || (length_in > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : length_in;
    assign w_first_idx  = IDX_W'(w_len_norm - LEN_W'(1));
    assign w_reload_idx = IDX_W'(r_len - LEN_W'(1));

`ifdef SEQ_TX_PARITY_EN
    logic [WIDTH-1:0]   w_mask;
    logic               w_par;

    // Shift wraps to zero at full width, so the subtraction yields all ones
    assign w_mask = (WIDTH'(1) << r_len) - WIDTH'(1);
    assign w_par  = ^(r_pat & w_mask);
`endif

    assign sequence_out = r_seq;
    assign frame_start  = r_fs;
    assign busy         = r_busy;
    assign done         = r_done;
    assign start_ready  = r_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_rep   <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_seq   <= IDLE_LEVEL;
            r_fs    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_rep   <= w_rep_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_seq   <= w_seq_nxt;
            r_fs    <= w_fs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_rep_nxt   = r_rep;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_seq_nxt   = IDLE_LEVEL;
        w_fs_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        w_frame_end = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready_nxt = 1'b1;
                if (start_valid && r_ready && !abort) begin
                    w_state_nxt = ST_SHIFT;
                    w_pat_nxt   = pattern_in;
                    w_len_nxt   = w_len_norm;
                    w_rep_nxt   = repeat_in;
                    w_idx_nxt   = w_first_idx;
                    w_seq_nxt   = pattern_in[w_first_idx];
                    w_fs_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                w_busy_nxt = 1'b1;
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                    w_seq_nxt = r_pat[r_idx - IDX_W'(1)];
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    w_state_nxt = ST_PAR;
                    w_seq_nxt   = w_par;
`else
                    w_frame_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PAR: begin
                w_busy_nxt  = 1'b1;
                w_frame_end = 1'b1;
            end
`endif
            ST_GAP: begin
                w_busy_nxt = 1'b1;
                if (r_gap == '0) begin
                    w_state_nxt = ST_SHIFT;
                    w_idx_nxt   = w_reload_idx;
                    w_seq_nxt   = r_pat[w_reload_idx];
                    w_fs_nxt    = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase

        // End of a frame: another frame (after an optional gap) or finish
        if (w_frame_end) begin
            if (r_rep != '0) begin
                w_rep_nxt = r_rep - CNT_W'(1);
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_SHIFT;
                    w_idx_nxt   = w_reload_idx;
                    w_seq_nxt   = r_pat[w_reload_idx];
                    w_fs_nxt    = 1'b1;
                end
            end else begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end
        end

        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_seq_nxt   = IDLE_LEVEL;
            w_fs_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_ready_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_sequence_pattern_tx.sv
// Bench for sequence_pattern_tx: table vectors, hand-written corner cases and random jobs
// checked cycle by cycle against a frame-list reference model.
module tb_sequence_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int          GAP   = 2;
    localparam logic        IDLE  = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    localparam int          PAR_EN = 1;
`else
    localparam int          PAR_EN = 0;
`endif

    // Output record layout: {sequence_out, frame_start, busy, done, start_ready}
    localparam logic [4:0] IDLE_REC = {IDLE, 4'b0001};

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] pattern_in = '0;
    logic [LEN_W-1:0] length_in = '0;
    logic [CNT_W-1:0] repeat_in = '0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic             abort = 1'b0;
    logic             sequence_out;
    logic             frame_start;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    sequence_pattern_tx #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYCLES(GAP), .IDLE_LEVEL(IDLE)
    ) dut (
        .clock(clock), .reset(reset), .pattern_in(pattern_in), .length_in(length_in),
        .repeat_in(repeat_in), .start_valid(start_valid), .start_ready(start_ready),
        .abort(abort), .sequence_out(sequence_out), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] outs();
        return {sequence_out, frame_start, busy, done, start_ready};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected per-cycle outputs of a job, built from frames, gaps and the done/idle tail.
    // Caller is just after a negedge; returns at a negedge of an IDLE cycle.
    task automatic run_job(input string name, input logic [WIDTH-1:0] pat,
                           input logic [LEN_W-1:0] len, input logic [CNT_W-1:0] rep,
                           input int abort_at, output int done_cyc);
        logic [4:0] exp_q[$];
        int         l;
        logic       par;
        done_cyc = -1;
        l = ((len == 0) || (int'(len) > int'(WIDTH))) ? int'(WIDTH) : int'(len);
        for (int f = 0; f <= int'(rep); f++) begin
            par = 1'b0;
            for (int b = l - 1; b >= 0; b--) begin
                exp_q.push_back({pat[b], (b == l - 1), 3'b100});
                par ^= pat[b];
            end
            if (PAR_EN != 0) exp_q.push_back({par, 4'b0100});
            if (f < int'(rep)) repeat (GAP) exp_q.push_back({IDLE, 4'b0100});
        end
        exp_q.push_back({IDLE, 4'b0110});
        exp_q.push_back(IDLE_REC);

        pattern_in  = pat;
        length_in   = len;
        repeat_in   = rep;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        pattern_in  = WIDTH'($urandom);
        length_in   = LEN_W'($urandom);
        repeat_in   = CNT_W'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            check($sformatf("%s_c%0d", name, i + 1), int'(outs()), int'(exp_q[i]));
            if (done && done_cyc < 0) done_cyc = i + 1;
            if (i == abort_at) begin
                abort = 1'b1;
                @(posedge clock);
                #1;
                abort = 1'b0;
                @(negedge clock);
                check($sformatf("%s_abort", name), int'(outs()), int'(IDLE_REC));
                break;
            end
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] rep;
        int               done_at;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int d;
        int ab;

        tbl[0] = '{8'h0B, 4'd4,  4'd0, 5};
        tbl[1] = '{8'h0B, 4'd4,  4'd2, 17};
        tbl[2] = '{8'hA5, 4'd0,  4'd0, 9};
        tbl[3] = '{8'hA5, 4'd15, 4'd0, 9};
        tbl[4] = '{8'h03, 4'd2,  4'd1, 7};
        tbl[5] = '{8'h80, 4'd8,  4'd1, 19};
        tbl[6] = '{8'h01, 4'd1,  4'd3, 11};
        tbl[7] = '{8'h5A, 4'd8,  4'd0, 9};

        #2 reset = 1'b1;
        #1 check("reset_async", int'(outs()), int'(IDLE_REC));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("after_reset", int'(outs()), int'(IDLE_REC));

        for (int t = 0; t < 8; t++) begin
            run_job($sformatf("tbl%0d", t), tbl[t].pat, tbl[t].len, tbl[t].rep, -1, d);
            check($sformatf("tbl%0d_done_at", t), d, tbl[t].done_at + PAR_EN * (int'(tbl[t].rep) + 1));
        end

        // Abort on the third bit of a three-frame job, then restart right away
        run_job("abort3", 8'h0B, 4'd4, 4'd2, 2, d);
        check("abort3_no_done", d, -1);
        run_job("after_abort", 8'h0B, 4'd4, 4'd0, -1, d);
        check("after_abort_done_at", d, 5 + PAR_EN);

        // Reset during the first gap of a two-frame job
        pattern_in  = 8'h0B;
        length_in   = 4'd4;
        repeat_in   = 4'd1;
        start_valid = 1'b1;
        @(posedge clock);
        #1 start_valid = 1'b0;
        repeat (5 + PAR_EN) @(negedge clock);
        check("mid_gap", int'(outs()), int'({IDLE, 4'b0100}));
        reset = 1'b1;
        #1 check("reset_mid_gap", int'(outs()), int'(IDLE_REC));
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("post_reset_idle%0d", i), int'(outs()), int'(IDLE_REC));
        end

        // Start together with abort in IDLE must not be accepted
        start_valid = 1'b1;
        abort       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("start_abort_idle%0d", i), int'(outs()), int'(IDLE_REC));
        end
        start_valid = 1'b0;
        abort       = 1'b0;
        @(negedge clock);
        run_job("recover", 8'hA5, 4'd0, 4'd0, -1, d);
        check("recover_done_at", d, 9 + PAR_EN);

        // Randomized jobs, some aborted at a random cycle
        for (int r = 0; r < 40; r++) begin
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : -1;
            run_job($sformatf("rnd%0d", r), WIDTH'($urandom), LEN_W'($urandom),
                    CNT_W'($urandom_range(3)), ab, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
